pusch_re_grid_mapper: RTL and testbench

//  Next-generation PUSCH resource-element mapper: writes one slot of allocated REs into the subcarrier-by-symbol grid memory.
//  Per-symbol DMRS/data selection comes from a bitmask; DMRS uses a comb of configurable size and offset, with zero fill between teeth.

---
 rtl/pusch_re_pkg.sv | 23 ++
 rtl/pusch_re_grid_mapper_if.sv | 50 +++++
 rtl/re_comb_ctr.sv | 39 +++
 rtl/pusch_re_grid_mapper.sv | 170 +++++++++++++++++
 tb/tb_pusch_re_grid_mapper.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pusch_re_pkg.sv
// Shared types and helpers for the PUSCH resource-element grid mapper.
package pusch_re_pkg;

    localparam int unsigned RB_SC = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SYM_SEL  = 2'd1,
        MAP_DMRS = 2'd2,
        MAP_DATA = 2'd3
    } state_t;

    // Number of sign bits prepended to a DMRS sample to reach the grid sample width.
    function automatic int unsigned sext_pad(input int unsigned iq_w, input int unsigned dmrs_w);
        return iq_w - dmrs_w;
    endfunction

    // Comb phase width; a comb of 1 still needs a one-bit phase register.
    function automatic int unsigned ph_width(input int unsigned comb);
        return (comb > 1) ? $clog2(comb) : 1;
    endfunction

endpackage

// File: rtl/pusch_re_grid_mapper_if.sv
// Config, DMRS/data input streams and grid-RAM write port of the RE mapper.
interface pusch_re_grid_mapper_if #(
    parameter int unsigned IQ_W   = 18,
    parameter int unsigned DMRS_W = 9,
    parameter int unsigned SC_W   = 11,
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned N_SYM  = 14,
    parameter int unsigned PH_W   = 1
);
    logic                 cfg_start;
    logic [SC_W-1:0]      n_sc;
    logic [6:0]           n_rb;
    logic [3:0]           sym_start;
    logic [3:0]           sym_end;
    logic [N_SYM-1:0]     dmrs_mask;
    logic [PH_W-1:0]      comb_off;

    logic [DMRS_W-1:0]    dmrs_i;
    logic [DMRS_W-1:0]    dmrs_q;
    logic                 dmrs_valid;
    logic                 dmrs_ready;

    logic [IQ_W-1:0]      data_i;
    logic [IQ_W-1:0]      data_q;
    logic                 data_valid;
    logic                 data_ready;

    logic [IQ_W-1:0]      re_i;
    logic [IQ_W-1:0]      re_q;
    logic                 re_valid;
    logic [ADDR_W-1:0]    re_addr;
    logic                 sym_done;
    logic                 map_done;
    logic                 busy;
    logic                 cfg_err;

    modport master (
        output cfg_start, n_sc, n_rb, sym_start, sym_end, dmrs_mask, comb_off,
        output dmrs_i, dmrs_q, dmrs_valid, data_i, data_q, data_valid,
        input  dmrs_ready, data_ready,
        input  re_i, re_q, re_valid, re_addr, sym_done, map_done, busy, cfg_err
    );

    modport slave (
        input  cfg_start, n_sc, n_rb, sym_start, sym_end, dmrs_mask, comb_off,
        input  dmrs_i, dmrs_q, dmrs_valid, data_i, data_q, data_valid,
        output dmrs_ready, data_ready,
        output re_i, re_q, re_valid, re_addr, sym_done, map_done, busy, cfg_err
    );
endinterface

// File: rtl/re_comb_ctr.sv
// Subcarrier counter with a parallel mod-COMB phase counter for DMRS tooth detection.
module re_comb_ctr #(
    parameter int unsigned SC_W = 11,
    parameter int unsigned COMB = 2,
    parameter int unsigned PH_W = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            adv_i,
    input  logic [SC_W-1:0] n_sc_i,
    input  logic [SC_W-1:0] last_i,
    input  logic [PH_W-1:0] comb_off_i,
    output logic [SC_W-1:0] sc_o,
    output logic            is_tooth_o,
    output logic            is_last_o
);
    logic [SC_W-1:0] sc_q;
    logic [PH_W-1:0] ph_q;

    // Phase tracks (sc - n_sc) mod COMB by wrapping instead of dividing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q <= '0;
            ph_q <= '0;
        end else if (load_i) begin
            sc_q <= n_sc_i;
            ph_q <= '0;
        end else if (adv_i) begin
            sc_q <= sc_q + SC_W'(1);
            ph_q <= (ph_q == PH_W'(COMB - 1)) ? '0 : ph_q + PH_W'(1);
        end
    end

    assign sc_o       = sc_q;
    assign is_tooth_o = (COMB == 1) ? 1'b1 : (ph_q == comb_off_i);
    assign is_last_o  = (sc_q == last_i);

endmodule

// File: rtl/pusch_re_grid_mapper.sv
// PUSCH RE mapper: walks one slot's allocation symbol by symbol and emits grid-RAM writes.
module pusch_re_grid_mapper
    import pusch_re_pkg::*;
#(
    parameter int unsigned IQ_W       = 18,
    parameter int unsigned DMRS_W     = 9,
    parameter int unsigned N_SC_TOTAL = 1200,
    parameter int unsigned N_SYM      = 14,
    parameter int unsigned COMB       = 2,
    parameter int unsigned SC_W       = 11,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic               CLK_RE,
    input  logic               RST_RE,
    pusch_re_grid_mapper_if.slave bus
);
    localparam int unsigned PH_W   = ph_width(COMB);
    localparam int unsigned CHK_W  = SC_W + 1;
    localparam int unsigned SYM_W  = 4;
    localparam int unsigned MASK_W = 1 << SYM_W;
    localparam int unsigned PAD_W  = sext_pad(IQ_W, DMRS_W);

    state_t              state_q;
    logic [SC_W-1:0]     n_sc_q;
    logic [SC_W-1:0]     last_q;
    logic [SYM_W-1:0]    sym_q;
    logic [SYM_W-1:0]    sym_end_q;
    logic [MASK_W-1:0]   mask_q;
    logic [PH_W-1:0]     comb_off_q;
    logic [ADDR_W-1:0]   base_q;

    logic [IQ_W-1:0]     re_i_q;
    logic [IQ_W-1:0]     re_q_q;
    logic                re_valid_q;
    logic [ADDR_W-1:0]   re_addr_q;
    logic                sym_done_q;
    logic                map_done_q;
    logic                busy_q;
    logic                cfg_err_q;

    logic [CHK_W-1:0]    end_c;
    logic                cfg_bad_c;
    logic                load_c;
    logic                adv_c;
    logic                dmrs_ready_c;
    logic                data_ready_c;
    logic [IQ_W-1:0]     smp_i_c;
    logic [IQ_W-1:0]     smp_q_c;
    logic [SC_W-1:0]     sc_c;
    logic                is_tooth_c;
    logic                is_last_c;

    re_comb_ctr #(
        .SC_W (SC_W),
        .COMB (COMB),
        .PH_W (PH_W)
    ) u_comb_ctr (
        .clk        (CLK_RE),
        .rst        (RST_RE),
        .load_i     (load_c),
        .adv_i      (adv_c),
        .n_sc_i     (n_sc_q),
        .last_i     (last_q),
        .comb_off_i (comb_off_q),
        .sc_o       (sc_c),
        .is_tooth_o (is_tooth_c),
        .is_last_o  (is_last_c)
    );

    // Config legality, stream handshakes and the sample that a given RE will carry.
    always_comb begin
        end_c        = CHK_W'(bus.n_sc) + CHK_W'(bus.n_rb) * CHK_W'(RB_SC);
        cfg_bad_c    = (end_c > CHK_W'(N_SC_TOTAL)) || (bus.n_rb == 7'd0) ||
                       (bus.sym_end < bus.sym_start) || (32'(bus.sym_end) >= 32'(N_SYM));
        load_c       = (state_q == SYM_SEL);
        dmrs_ready_c = (state_q == MAP_DMRS) && is_tooth_c;
        data_ready_c = (state_q == MAP_DATA);
        adv_c        = ((state_q == MAP_DMRS) && (!is_tooth_c || bus.dmrs_valid)) ||
                       (data_ready_c && bus.data_valid);
        smp_i_c      = '0;
        smp_q_c      = '0;
        if (data_ready_c) begin
            smp_i_c = bus.data_i;
            smp_q_c = bus.data_q;
        end else if (dmrs_ready_c) begin
            smp_i_c = {{PAD_W{bus.dmrs_i[DMRS_W-1]}}, bus.dmrs_i};
            smp_q_c = {{PAD_W{bus.dmrs_q[DMRS_W-1]}}, bus.dmrs_q};
        end
    end

    always_ff @(posedge CLK_RE or posedge RST_RE) begin
        if (RST_RE) begin
            state_q    <= IDLE;
            n_sc_q     <= '0;
            last_q     <= '0;
            sym_q      <= '0;
            sym_end_q  <= '0;
            mask_q     <= '0;
            comb_off_q <= '0;
            base_q     <= '0;
            re_i_q     <= '0;
            re_q_q     <= '0;
            re_valid_q <= 1'b0;
            re_addr_q  <= '0;
            sym_done_q <= 1'b0;
            map_done_q <= 1'b0;
            busy_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            re_valid_q <= 1'b0;
            sym_done_q <= 1'b0;
            map_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cfg_start) begin
                        if (cfg_bad_c) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            n_sc_q     <= bus.n_sc;
                            last_q     <= SC_W'(end_c - CHK_W'(1));
                            sym_q      <= bus.sym_start;
                            sym_end_q  <= bus.sym_end;
                            mask_q     <= MASK_W'(bus.dmrs_mask);
                            comb_off_q <= bus.comb_off;
                            busy_q     <= 1'b1;
                            state_q    <= SYM_SEL;
                        end
                    end
                end
                SYM_SEL: begin
                    base_q  <= ADDR_W'(sym_q) * ADDR_W'(N_SC_TOTAL);
                    state_q <= mask_q[sym_q] ? MAP_DMRS : MAP_DATA;
                end
                MAP_DMRS, MAP_DATA: begin
                    if (adv_c) begin
                        re_valid_q <= 1'b1;
                        re_addr_q  <= base_q + ADDR_W'(sc_c);
                        re_i_q     <= smp_i_c;
                        re_q_q     <= smp_q_c;
                        if (is_last_c) begin
                            sym_done_q <= 1'b1;
                            if (sym_q == sym_end_q) begin
                                map_done_q <= 1'b1;
                                busy_q     <= 1'b0;
                                state_q    <= IDLE;
                            end else begin
                                sym_q   <= sym_q + SYM_W'(1);
                                state_q <= SYM_SEL;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dmrs_ready = dmrs_ready_c;
    assign bus.data_ready = data_ready_c;
    assign bus.re_i       = re_i_q;
    assign bus.re_q       = re_q_q;
    assign bus.re_valid   = re_valid_q;
    assign bus.re_addr    = re_addr_q;
    assign bus.sym_done   = sym_done_q;
    assign bus.map_done   = map_done_q;
    assign bus.busy       = busy_q;
    assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pusch_re_grid_mapper.sv
// Scoreboard bench for pusch_re_grid_mapper: a slot-level model predicts every grid write.
module tb_pusch_re_grid_mapper;
    localparam int unsigned IQ_W   = 18;
    localparam int unsigned DMRS_W = 9;
    localparam int unsigned N_SC   = 1200;
    localparam int unsigned N_SYM  = 14;
    localparam int unsigned COMB   = 2;
    localparam int unsigned SC_W   = 11;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned PH_W   = 1;
    localparam int          BOUND  = 20000;

    typedef struct {
        int addr;
        int ri;
        int rq;
        bit sd;
        bit md;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pusch_re_grid_mapper_if #(
        .IQ_W(IQ_W), .DMRS_W(DMRS_W), .SC_W(SC_W), .ADDR_W(ADDR_W), .N_SYM(N_SYM), .PH_W(PH_W)
    ) bus ();

    pusch_re_grid_mapper #(
        .IQ_W(IQ_W), .DMRS_W(DMRS_W), .N_SC_TOTAL(N_SC), .N_SYM(N_SYM),
        .COMB(COMB), .SC_W(SC_W), .ADDR_W(ADDR_W)
    ) dut (
        .CLK_RE (clk),
        .RST_RE (rst),
        .bus    (bus)
    );

    exp_t                   exp_q[$];
    logic [2*DMRS_W-1:0]    dm_q[$];
    logic [2*IQ_W-1:0]      dt_q[$];
    int  checks = 0;
    int  failures = 0;
    int  wr_cnt = 0;
    int  cfg_err_cnt = 0;
    int  last_md_addr = -1;
    bit  map_seen = 0;
    int  dmrs_pct = 100;
    int  data_pct = 100;
    bit  data_toggle = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Slot model: walk symbols and subcarriers, consuming fresh samples in stream order.
    task automatic build_slot(input int nsc, input int nrb, input int s0, input int s1,
                              input logic [N_SYM-1:0] mask, input int off, input bit fixed_neg);
        logic signed [DMRS_W-1:0] di, dq;
        logic signed [IQ_W-1:0]   ti, tq;
        exp_t e;
        int last;
        dm_q.delete();
        dt_q.delete();
        last = nsc + 12 * nrb - 1;
        for (int s = s0; s <= s1; s++) begin
            for (int sc = nsc; sc <= last; sc++) begin
                e.addr = s * N_SC + sc;
                if (mask[s]) begin
                    if (((sc - nsc) % COMB) == off) begin
                        di = fixed_neg ? '1 : DMRS_W'($urandom);
                        dq = DMRS_W'($urandom);
                        dm_q.push_back({di, dq});
                        e.ri = int'(di);
                        e.rq = int'(dq);
                    end else begin
                        e.ri = 0;
                        e.rq = 0;
                    end
                end else begin
                    ti = IQ_W'($urandom);
                    tq = IQ_W'($urandom);
                    dt_q.push_back({ti, tq});
                    e.ri = int'(ti);
                    e.rq = int'(tq);
                end
                e.sd = (sc == last);
                e.md = (sc == last) && (s == s1);
                exp_q.push_back(e);
            end
        end
        for (int k = 0; k < 2; k++) begin
            dm_q.push_back({DMRS_W'($urandom), DMRS_W'($urandom)});
            dt_q.push_back({IQ_W'($urandom), IQ_W'($urandom)});
        end
    endtask

    task automatic pulse_cfg(input int nsc, input int nrb, input int s0, input int s1,
                             input logic [N_SYM-1:0] mask, input int off);
        @(posedge clk); #1;
        bus.n_sc      = SC_W'(nsc);
        bus.n_rb      = 7'(nrb);
        bus.sym_start = 4'(s0);
        bus.sym_end   = 4'(s1);
        bus.dmrs_mask = mask;
        bus.comb_off  = PH_W'(off);
        bus.cfg_start = 1'b1;
        @(posedge clk); #1;
        bus.cfg_start = 1'b0;
        bus.n_sc      = SC_W'($urandom);
        bus.n_rb      = 7'($urandom);
        bus.sym_start = 4'($urandom);
        bus.sym_end   = 4'($urandom);
        bus.dmrs_mask = N_SYM'($urandom);
        bus.comb_off  = PH_W'($urandom);
    endtask

    task automatic start_slot(input int nsc, input int nrb, input int s0, input int s1,
                              input logic [N_SYM-1:0] mask, input int off, input bit fixed_neg);
        build_slot(nsc, nrb, s0, s1, mask, off, fixed_neg);
        map_seen = 0;
        pulse_cfg(nsc, nrb, s0, s1, mask, off);
        @(negedge clk);
        chk("busy_after_cfg", bus.busy, 1);
        chk("no_cfg_err_on_good", bus.cfg_err, 0);
    endtask

    task automatic finish_slot();
        int k;
        for (k = 0; k < BOUND && !map_seen; k++) @(negedge clk);
        if (!map_seen) begin
            failures++;
            checks++;
            $display("FAIL map_done_timeout actual=none required=pulse within %0d cycles", BOUND);
        end
        @(negedge clk);
        chk("busy_after_done", bus.busy, 0);
        chk("pending_expected", exp_q.size(), 0);
        chk("dmrs_left_unconsumed", dm_q.size(), 2);
        chk("data_left_unconsumed", dt_q.size(), 2);
    endtask

    task automatic try_bad(input int nsc, input int nrb, input int s0, input int s1, input string nm);
        int c0, w0;
        c0 = cfg_err_cnt;
        w0 = wr_cnt;
        pulse_cfg(nsc, nrb, s0, s1, N_SYM'(1), 0);
        @(negedge clk);
        chk({nm, "_cfg_err"}, bus.cfg_err, 1);
        chk({nm, "_busy"}, bus.busy, 0);
        repeat (3) @(negedge clk);
        chk({nm, "_err_pulses"}, cfg_err_cnt - c0, 1);
        chk({nm, "_writes"}, wr_cnt - w0, 0);
        chk({nm, "_busy_later"}, bus.busy, 0);
    endtask

    // DMRS stream driver: holds the head sample, drops it once a handshake is seen.
    initial begin : dmrs_drv
        bit hs;
        bus.dmrs_valid = 1'b0;
        bus.dmrs_i = '0;
        bus.dmrs_q = '0;
        forever begin
            @(negedge clk);
            hs = bus.dmrs_valid && bus.dmrs_ready;
            @(posedge clk); #1;
            if (hs && dm_q.size() > 0) void'(dm_q.pop_front());
            if (dm_q.size() > 0) begin
                bus.dmrs_valid = ($urandom_range(99) < dmrs_pct);
                {bus.dmrs_i, bus.dmrs_q} = dm_q[0];
            end else begin
                bus.dmrs_valid = 1'b0;
            end
        end
    end

    initial begin : data_drv
        bit hs;
        bus.data_valid = 1'b0;
        bus.data_i = '0;
        bus.data_q = '0;
        forever begin
            @(negedge clk);
            hs = bus.data_valid && bus.data_ready;
            @(posedge clk); #1;
            if (hs && dt_q.size() > 0) void'(dt_q.pop_front());
            if (dt_q.size() > 0) begin
                bus.data_valid = data_toggle ? !bus.data_valid : ($urandom_range(99) < data_pct);
                {bus.data_i, bus.data_q} = dt_q[0];
            end else begin
                bus.data_valid = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.cfg_err) cfg_err_cnt++;
            if (bus.re_valid) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=addr %0d required=no write", bus.re_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("re_addr", bus.re_addr, e.addr);
                    chk("re_i", int'($signed(bus.re_i)), e.ri);
                    chk("re_q", int'($signed(bus.re_q)), e.rq);
                    chk("sym_done", bus.sym_done, e.sd);
                    chk("map_done", bus.map_done, e.md);
                end
                if (bus.map_done) begin
                    map_seen = 1;
                    last_md_addr = int'(bus.re_addr);
                end
            end else if (bus.sym_done || bus.map_done) begin
                checks++;
                failures++;
                $display("FAIL stray_done_pulse actual=sym_done %0b map_done %0b required=0 0",
                         bus.sym_done, bus.map_done);
            end
        end
    end

    initial begin : main
        int w0, c0, nrb, nsc, s0, s1;
        bus.cfg_start = 1'b0;
        bus.n_sc = '0;
        bus.n_rb = '0;
        bus.sym_start = '0;
        bus.sym_end = '0;
        bus.dmrs_mask = '0;
        bus.comb_off = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_re_valid", bus.re_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        chk("rst_dmrs_ready", bus.dmrs_ready, 0);
        chk("rst_data_ready", bus.data_ready, 0);
        chk("rst_map_done", bus.map_done, 0);
        chk("rst_re_addr", bus.re_addr, 0);
        rst = 1'b0;

        // Comb DMRS symbol then a data symbol, streams always valid.
        start_slot(0, 1, 2, 3, 14'h004, 0, 0);
        finish_slot();
        chk("t1_map_done_addr", last_md_addr, 3611);

        // Odd comb offset, negative DMRS samples sign-extended.
        start_slot(100, 2, 0, 1, 14'h001, 1, 1);
        finish_slot();
        chk("t2_map_done_addr", last_md_addr, 1200 + 123);

        // Data stream toggling valid every cycle.
        data_toggle = 1;
        start_slot(24, 1, 5, 5, 14'h000, 0, 0);
        finish_slot();
        data_toggle = 0;

        // Rejected configurations.
        try_bad(1190, 1, 0, 0, "sc_overflow");
        try_bad(0, 1, 5, 3, "sym_order");
        try_bad(0, 0, 0, 0, "zero_rb");
        try_bad(0, 1, 0, 14, "sym_range");

        // cfg_start while busy is ignored, then reset aborts the slot mid-way.
        c0 = cfg_err_cnt;
        start_slot(0, 2, 0, 1, 14'h001, 0, 0);
        pulse_cfg(1190, 1, 4, 2, 14'h000, 0);
        @(negedge clk);
        chk("midslot_busy", bus.busy, 1);
        chk("midslot_no_cfg_err", cfg_err_cnt - c0, 0);
        w0 = wr_cnt;
        for (int k = 0; k < 200 && (wr_cnt - w0) < 5; k++) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_re_valid", bus.re_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_dmrs_ready", bus.dmrs_ready, 0);
        chk("abort_data_ready", bus.data_ready, 0);
        chk("abort_sym_done", bus.sym_done, 0);
        chk("abort_re_addr", bus.re_addr, 0);
        exp_q.delete();
        dm_q.delete();
        dt_q.delete();
        w0 = wr_cnt;
        repeat (3) @(negedge clk);
        chk("abort_no_writes", wr_cnt - w0, 0);
        rst = 1'b0;
        start_slot(0, 2, 0, 1, 14'h001, 0, 0);
        finish_slot();

        // Top corner of the grid.
        start_slot(1188, 1, 13, 13, 14'h000, 0, 0);
        finish_slot();
        chk("t6_last_addr", last_md_addr, 16799);

        // Randomized slots with random stream throttling.
        for (int r = 0; r < 8; r++) begin
            nrb = $urandom_range(1, 3);
            nsc = $urandom_range(0, N_SC - 12 * nrb);
            s0  = $urandom_range(0, N_SYM - 1);
            s1  = $urandom_range(s0, (s0 + 2 > N_SYM - 1) ? N_SYM - 1 : s0 + 2);
            dmrs_pct = $urandom_range(40, 100);
            data_pct = $urandom_range(40, 100);
            start_slot(nsc, nrb, s0, s1, N_SYM'($urandom), $urandom_range(0, COMB - 1), 0);
            finish_slot();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
